// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - register file constants and write-back request type shared by the scheduler and requesters
package rf_pkg;

  localparam int NREGS = 10;
  localparam int XLEN  = 32;
  localparam int AW    = 5;

  localparam int GNT_ALU = 0;
  localparam int GNT_MEM = 1;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  function automatic logic rd_in_range(input logic [AW-1:0] rd);
    return rd < AW'(NREGS);
  endfunction

endpackage

// File: rtl/rf_wb_arb2.sv
// rtl/rf_wb_arb2.sv - two-way write-back grant; WB_RR_EN selects round-robin, otherwise mem over alu
module rf_wb_arb2 import rf_pkg::*; (
`ifdef WB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic       alu_valid,
  input  logic       mem_valid,
  output logic [1:0] grant
);

`ifdef WB_RR_EN
  // pref_mem_q set means mem wins the next tie; reset favours the ALU.
  logic pref_mem_q, pref_mem_d;

  always_comb begin
    grant = 2'b00;
    if (alu_valid && mem_valid) begin
      grant[GNT_MEM] = pref_mem_q;
      grant[GNT_ALU] = !pref_mem_q;
    end else begin
      grant[GNT_MEM] = mem_valid;
      grant[GNT_ALU] = alu_valid;
    end
  end

  always_comb begin
    pref_mem_d = pref_mem_q;
    if (grant[GNT_ALU]) begin
      pref_mem_d = 1'b1;
    end else if (grant[GNT_MEM]) begin
      pref_mem_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pref_mem_q <= 1'b0;
    end else begin
      pref_mem_q <= pref_mem_d;
    end
  end
`else
  always_comb begin
    grant          = 2'b00;
    grant[GNT_MEM] = mem_valid;
    grant[GNT_ALU] = alu_valid && !mem_valid;
  end
`endif

endmodule

// File: rtl/rf_wb_sched.sv
// rtl/rf_wb_sched.sv - register file write-back scheduler and busy scoreboard (WB_RR_EN: round-robin arbitration)
module rf_wb_sched import rf_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_rd_en,
  output logic            issue_ready,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wbdata,
  output logic            addr_err
);

  logic [1:0]       grant;
  wb_req_t          alu_req, mem_req, sel_req;
  logic             xfer;

  logic             rf_we_q, rf_we_d;
  logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wbdata_q, rf_wbdata_d;
  logic             addr_err_q, addr_err_d;
  logic [NREGS-1:0] busy_q, busy_d;

  rf_wb_arb2 u_arb (
`ifdef WB_RR_EN
    .clk       (clk),
    .reset     (reset),
`endif
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .grant     (grant)
  );

  assign alu_req   = '{rd: alu_rd, data: alu_data};
  assign mem_req   = '{rd: mem_rd, data: mem_data};
  assign sel_req   = grant[GNT_MEM] ? mem_req : alu_req;
  assign xfer      = |grant;
  assign alu_ready = grant[GNT_ALU];
  assign mem_ready = grant[GNT_MEM];

  assign issue_ready = !(issue_rd_en && rd_in_range(issue_rd) && busy_q[issue_rd]);
  assign rs1_busy    = rd_in_range(rs1) && busy_q[rs1];
  assign rs2_busy    = rd_in_range(rs2) && busy_q[rs2];

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wbdata = rf_wbdata_q;
  assign addr_err  = addr_err_q;

  // Out-of-range destinations are consumed but never reach the register file.
  always_comb begin
    rf_we_d     = xfer && rd_in_range(sel_req.rd);
    addr_err_d  = xfer && !rd_in_range(sel_req.rd);
    rf_waddr_d  = rf_waddr_q;
    rf_wbdata_d = rf_wbdata_q;
    if (rf_we_d) begin
      rf_waddr_d  = sel_req.rd;
      rf_wbdata_d = sel_req.data;
    end
  end

  // Clear before set so a new issue to the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && issue_ready && issue_rd_en && rd_in_range(issue_rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wbdata_q <= '0;
      addr_err_q  <= 1'b0;
      busy_q      <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wbdata_q <= rf_wbdata_d;
      addr_err_q  <= addr_err_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb/tb_rf_wb_sched.sv - directed self-checking bench for rf_wb_sched (expectations follow WB_RR_EN)
module tb_rf_wb_sched;

  logic        clk;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid, issue_rd_en;
  logic [4:0]  alu_rd, mem_rd, issue_rd, rs1, rs2, rf_waddr;
  logic [31:0] alu_data, mem_data, rf_wbdata;
  logic        alu_ready, mem_ready, issue_ready, rs1_busy, rs2_busy, rf_we, addr_err;

  int checks;
  int failures;

  rf_wb_sched dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rd_en (issue_rd_en),
    .issue_ready (issue_ready),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wbdata   (rf_wbdata),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic before_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic exp_mem;
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    alu_valid   = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid   = 1'b0; mem_rd = '0; mem_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_rd_en = 1'b0;
    rs1 = '0; rs2 = '0;

    after_edge();
    after_edge();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wbdata", rf_wbdata, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // single ALU write-back
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'd1);
    chk("alu_mem_ready_low", 32'(mem_ready), 32'd0);
    after_edge();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd3);
    chk("alu_wbdata", rf_wbdata, 32'hDEADBEEF);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    chk("alu_ready_idle", 32'(alu_ready), 32'd0);
    after_edge();
    chk("alu_we_drop", 32'(rf_we), 32'd0);

    // contention: mem wins first in both modes (ALU was granted last)
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
    #1;
    chk("cont_mem_ready", 32'(mem_ready), 32'd1);
    chk("cont_alu_ready", 32'(alu_ready), 32'd0);
    after_edge();
    chk("cont_waddr_mem", 32'(rf_waddr), 32'd2);
    chk("cont_data_mem", rf_wbdata, 32'h22);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("cont_alu_ready2", 32'(alu_ready), 32'd1);
    after_edge();
    chk("cont_waddr_alu", 32'(rf_waddr), 32'd1);
    chk("cont_data_alu", rf_wbdata, 32'h11);

    // both held valid for four cycles
    @(negedge clk);
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
`ifdef WB_RR_EN
      exp_mem = (i % 2 == 0);
`else
      exp_mem = 1'b1;
`endif
      chk($sformatf("hold_mem_ready_%0d", i), 32'(mem_ready), 32'(exp_mem));
      chk($sformatf("hold_alu_ready_%0d", i), 32'(alu_ready), 32'(!exp_mem));
      @(negedge clk);
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    after_edge();

    // scoreboard RAW/WAW
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rd_en = 1'b1;
    #1;
    chk("sb_issue_ready0", 32'(issue_ready), 32'd1);
    before_edge();
    issue_valid = 1'b0;
    rs1 = 5'd5; rs2 = 5'd6;
    #1;
    chk("sb_rs1_busy", 32'(rs1_busy), 32'd1);
    chk("sb_rs2_free", 32'(rs2_busy), 32'd0);
    chk("sb_waw_stall", 32'(issue_ready), 32'd0);
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'h55;
    #1;
    chk("sb_mem_ready", 32'(mem_ready), 32'd1);
    after_edge();
    chk("sb_we", 32'(rf_we), 32'd1);
    chk("sb_waddr", 32'(rf_waddr), 32'd5);
    chk("sb_rs1_busy_we", 32'(rs1_busy), 32'd1);
    @(negedge clk);
    mem_valid = 1'b0;
    #1;
    chk("sb_rs1_busy_we2", 32'(rs1_busy), 32'd1);
    after_edge();
    chk("sb_rs1_clear", 32'(rs1_busy), 32'd0);
    chk("sb_issue_ready1", 32'(issue_ready), 32'd1);

    // set and clear of r7 on the same edge
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    after_edge();
    chk("sc_we", 32'(rf_we), 32'd1);
    chk("sc_waddr", 32'(rf_waddr), 32'd7);
    @(negedge clk);
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rd_en = 1'b1;
    #1;
    chk("sc_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    issue_valid = 1'b0;
    rs1 = 5'd7;
    #1;
    chk("sc_busy7", 32'(rs1_busy), 32'd1);

    // out-of-range destination
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hCC;
    rs2 = 5'd12;
    #1;
    chk("oor_mem_ready", 32'(mem_ready), 32'd1);
    after_edge();
    chk("oor_we", 32'(rf_we), 32'd0);
    chk("oor_addr_err", 32'(addr_err), 32'd1);
    chk("oor_busy7", 32'(rs1_busy), 32'd1);
    chk("oor_rs2_busy", 32'(rs2_busy), 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    after_edge();
    chk("oor_addr_err_pulse", 32'(addr_err), 32'd0);

    // asynchronous reset while busy[4]=1 and rf_we=1
    @(negedge clk);
    issue_valid = 1'b1; issue_rd = 5'd4; issue_rd_en = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    rs1 = 5'd4; rs2 = 5'd7;
    after_edge();
    issue_valid = 1'b0; alu_valid = 1'b0;
    chk("ar_pre_we", 32'(rf_we), 32'd1);
    chk("ar_pre_busy4", 32'(rs1_busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_we", 32'(rf_we), 32'd0);
    chk("ar_busy4", 32'(rs1_busy), 32'd0);
    chk("ar_busy7", 32'(rs2_busy), 32'd0);
    chk("ar_waddr", 32'(rf_waddr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    issue_rd = 5'd7; issue_rd_en = 1'b1;
    #1;
    chk("ar_issue_ready", 32'(issue_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
Write-back scheduler and scoreboard for the 10-entry, 32-bit register file. Shares the register file's single write port between two requesters, the ALU and the memory/load unit, using valid/ready handshakes. Tracks pending destination registers so the issue stage can stall on RAW and WAW hazards. Drives the register file's we/waddr/wbdata inputs from registered outputs.

Parameters:
NREGS, 10, number of architectural registers; valid addresses are 0..NREGS-1
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
alu_valid  in  1  ALU write-back request
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU request accepted this cycle
mem_valid  in  1  load write-back request
mem_rd  in  AW  load destination register
mem_data  in  XLEN  load data
mem_ready  out  1  load request accepted this cycle
issue_valid  in  1  issue stage presents an instruction
issue_rd  in  AW  destination of the issuing instruction
issue_rd_en  in  1  instruction writes a register
issue_ready  out  1  issue may proceed (no WAW hazard)
rs1  in  AW  source 1 address of the issuing instruction
rs2  in  AW  source 2 address of the issuing instruction
rs1_busy  out  1  source 1 has a pending write (RAW hazard)
rs2_busy  out  1  source 2 has a pending write (RAW hazard)
rf_we  out  1  register file write enable
rf_waddr  out  AW  register file write address
rf_wbdata  out  XLEN  register file write data
addr_err  out  1  one-cycle pulse: a write-back was dropped because its address was >= NREGS

Behaviour:
- Reset (reset=0, asynchronous): rf_we=0, rf_waddr=0, rf_wbdata=0, addr_err=0, all scoreboard bits=0, round-robin pointer selects ALU. Reset applied mid-operation discards any in-flight grant and clears all pending bits.
- Arbitration (combinational): at most one of alu_ready/mem_ready is high, and only when the matching valid is high. A ready is never raised without its valid. A transfer occurs on valid&&ready at the clock edge.
- Default arbitration is fixed priority: mem beats alu when both are valid. Requesters hold valid, rd and data stable until the transfer completes.
- Latency: a transfer at edge N gives rf_we=1, rf_waddr=rd, rf_wbdata=data during cycle N+1. The register file commits the write at edge N+1. rf_we=0 in any cycle that had no transfer on the preceding edge.
- Out-of-range rd (>= NREGS): the request is still accepted (ready=1). rf_we stays 0 in the next cycle. addr_err=1 for that one cycle. The scoreboard is unchanged.
- Scoreboard: a busy[NREGS] bit vector.
  - Set at the edge where issue_valid && issue_ready && issue_rd_en && issue_rd<NREGS.
  - Cleared at the edge where rf_we && rf_waddr==r.
  - If a set and a clear of the same register coincide, set wins.
- issue_ready = !(issue_rd_en && issue_rd<NREGS && busy[issue_rd]). This stalls WAW hazards.
- rs1_busy = rs1<NREGS && busy[rs1]. rs2_busy is defined the same way. Both are combinational from the current busy vector, with no bypass of the write committing this cycle. A busy register therefore reads as busy through the cycle in which rf_we is high for it, and reads as clear from the next cycle onward.
- Write-backs to a register that is not marked busy are performed anyway; the scoreboard is unaffected.

Optional Feature:
Macro WB_RR_EN.
- Defined: two-way round-robin. When both requesters are valid, the one not granted most recently wins. The pointer updates only on a completed transfer.
- Undefined: fixed priority, mem over alu, with no pointer flop.

Decomposition:
- Package rf_pkg: NREGS, XLEN, AW constants and typedef wb_req_t (rd, data) shared by the register file, this block and the requesters.
- One sub-module, rf_wb_arb2: two-way grant logic. It contains the WB_RR_EN pointer and outputs a one-hot grant.
- The scoreboard and the output registers stay in rf_wb_sched.

Test Plan:
- Reset then single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wbdata=0xDEADBEEF; following cycle rf_we=0.
- Contention: alu (rd=1, 0x11) and mem (rd=2, 0x22) both valid -> fixed: mem first, then alu next cycle. With WB_RR_EN and both held valid for 4 cycles -> grants alternate.
- Scoreboard RAW/WAW: issue rd=5 -> next cycle rs1=5 gives rs1_busy=1 and issue rd=5 gives issue_ready=0. Mem writes rd=5 -> rs1_busy stays 1 through the rf_we cycle and is 0 on the cycle after.
- Simultaneous set/clear: rf_we for rd=7 in the same cycle that issue rd=7 is accepted -> busy[7] remains 1.
- Out of range: mem_rd=12 -> mem_ready=1, rf_we=0 and addr_err=1 next cycle, no busy bit changes.
- Async reset mid-stream: assert reset between clock edges while busy[4]=1 and rf_we=1 -> rf_we=0 and all busy bits 0 immediately, without waiting for a clock edge.
